// File: rtl/rf_word_loader_pkg.sv
// Shared defaults and FSM state encoding for the RF16 clock-enabled register bank writers.
package rf_word_loader_pkg;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_BYTE_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/rf_wr_decoder.sv
// Address to one-hot clock-enable decoder for the register bank; shared by every bank writer.
module rf_wr_decoder #(
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign onehot[gi] = en && (addr == ADDR_W'(gi));
    end
  endgenerate
endmodule

// File: rtl/rf_word_loader.sv
// Byte-stream to 16-bit word writer: pairs little-endian bytes and issues one-hot clock enables
// into consecutive bank registers, wrapping at the end of the bank.
module rf_word_loader
  import rf_word_loader_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BYTE_W   = DEF_BYTE_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk_n,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BYTE_W-1:0]   in_byte,
  input  logic                in_last,
  output logic [NUM_REGS-1:0] wr_clk_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                busy,
  output logic                done,
  output logic                err_odd
);
  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     ptr_reg;
  logic [DATA_W-1:0]     wr_data_reg;
  logic [NUM_REGS-1:0]   wr_clk_en_reg;
  logic [NUM_REGS-1:0]   dec_onehot;
  logic                  end_reg;
  logic                  err_odd_reg;
  logic                  accept;
  logic                  write_next;

  assign accept     = in_valid && in_ready;
  assign write_next = (state_next == ST_WRITE);

  // Enable is decoded one cycle early so the bank sees a flop output, never a decoder glitch.
  rf_wr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .addr   (ptr_reg),
    .en     (write_next),
    .onehot (dec_onehot)
  );

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LO;
      ST_LO:    if (accept) state_next = in_last ? ST_WRITE : ST_HI;
      ST_HI:    if (accept) state_next = ST_WRITE;
      ST_WRITE: state_next = end_reg ? ST_DONE : ST_LO;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_reg)
      ST_IDLE:      busy     = 1'b0;
      ST_LO, ST_HI: in_ready = 1'b1;
      ST_DONE:      done     = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      wr_data_reg   <= '0;
      wr_clk_en_reg <= '0;
      end_reg       <= 1'b0;
      err_odd_reg   <= 1'b0;
    end else begin
      wr_clk_en_reg <= dec_onehot;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            ptr_reg     <= start_addr;
            err_odd_reg <= 1'b0;
            end_reg     <= 1'b0;
          end
        end
        ST_LO: begin
          if (accept) begin
            wr_data_reg[BYTE_W-1:0] <= in_byte;
            // A lone trailing byte is written zero-extended and flagged.
            if (in_last) begin
              wr_data_reg[DATA_W-1:BYTE_W] <= '0;
              err_odd_reg                  <= 1'b1;
              end_reg                      <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (accept) begin
            wr_data_reg[DATA_W-1:BYTE_W] <= in_byte;
            end_reg                      <= in_last;
          end
        end
        ST_WRITE: ptr_reg <= ptr_reg + ADDR_W'(1);
        default:  ;
      endcase
    end
  end

  assign wr_clk_en = wr_clk_en_reg;
  assign wr_data   = wr_data_reg;
  assign err_odd   = err_odd_reg;
endmodule
